// File: rtl/factor_pkg.sv
// Shared definitions for the factorization game controller: display state
// codes, score ceiling and the prime selection decode.
package factor_pkg;

   localparam logic [3:0] ST_READY    = 4'b0010;
   localparam logic [3:0] ST_QUESTION = 4'b0011;
   localparam logic [3:0] ST_INPUT    = 4'b0100;
   localparam logic [3:0] ST_RIGHT    = 4'b0111;
   localparam logic [3:0] ST_FAIL     = 4'b1000;

   localparam logic [3:0] SCORE_MAX = 4'd9;

   typedef enum logic [3:0] {
      S_READY    = ST_READY,
      S_QUESTION = ST_QUESTION,
      S_INPUT    = ST_INPUT,
      S_RIGHT    = ST_RIGHT,
      S_FAIL     = ST_FAIL
   } state_t;

   function automatic logic [2:0] prime_of(input logic [3:0] din);
      case (din)
         4'd1:    prime_of = 3'd2;
         4'd2:    prime_of = 3'd3;
         4'd3:    prime_of = 3'd5;
         4'd4:    prime_of = 3'd7;
         default: prime_of = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/factor_que_gen.sv
// Free-running 2..9 question counter; the current value is captured into
// que when latch is pulsed.
module factor_que_gen (
   input  logic       clk,
   input  logic       rst,
   input  logic       latch,
   output logic [3:0] que
);

   logic [3:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 4'd2;
         que <= 4'd0;
      end else begin
         cnt <= (cnt == 4'd9) ? 4'd2 : cnt + 4'd1;
         if (latch)
            que <= cnt;
      end
   end

endmodule

// File: rtl/factor_game_ctrl.sv
// Round sequencer for the factorization game: READY -> QUESTION -> INPUT ->
// RIGHT/FAIL -> READY. Define FACTOR_TIMEOUT_EN to fail an idle INPUT phase.
module factor_game_ctrl
   import factor_pkg::*;
#(
   parameter int SHOW_CYC    = 50_000_000,
   parameter int RESULT_CYC  = 50_000_000,
   parameter int TIMEOUT_CYC = 250_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_START,
   input  logic       BTN_NEXT,
   input  logic       BTN_ENTER,
   output logic [3:0] STATE,
   output logic [3:0] QUE,
   output logic [3:0] DIN,
   output logic [3:0] SCORE
);

   localparam int MAX_SR = (SHOW_CYC > RESULT_CYC) ? SHOW_CYC : RESULT_CYC;
   localparam int MAX_C  = (MAX_SR > TIMEOUT_CYC) ? MAX_SR : TIMEOUT_CYC;
   localparam int HW     = $clog2(MAX_C) + 1;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [5:0]    prod_q, prod_d;
   logic [3:0]    din_q, din_d;
   logic [3:0]    score_q, score_d;
   logic          latch;
   logic [5:0]    np;
   logic [5:0]    que6;

`ifdef FACTOR_TIMEOUT_EN
   logic [HW-1:0] to_q, to_d;
`endif

   factor_que_gen u_que (
      .clk   (CLK),
      .rst   (RST),
      .latch (latch),
      .que   (QUE)
   );

   // Product never exceeds QUE (<= 9), so the 6-bit product cannot overflow.
   assign np   = prod_q * {3'b000, prime_of(din_q)};
   assign que6 = {2'b00, QUE};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_READY;
         hold_q  <= '0;
         prod_q  <= 6'd1;
         din_q   <= 4'd0;
         score_q <= 4'd0;
`ifdef FACTOR_TIMEOUT_EN
         to_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         prod_q  <= prod_d;
         din_q   <= din_d;
         score_q <= score_d;
`ifdef FACTOR_TIMEOUT_EN
         to_q    <= to_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      prod_d  = prod_q;
      din_d   = din_q;
      score_d = score_q;
      latch   = 1'b0;
`ifdef FACTOR_TIMEOUT_EN
      to_d    = to_q;
`endif
      case (state_q)
         S_READY: begin
            if (BTN_START) begin
               latch   = 1'b1;
               state_d = S_QUESTION;
               prod_d  = 6'd1;
               hold_d  = HW'(SHOW_CYC - 1);
            end
         end
         S_QUESTION: begin
            if (hold_q == '0) begin
               state_d = S_INPUT;
               din_d   = 4'd1;
`ifdef FACTOR_TIMEOUT_EN
               to_d    = '0;
`endif
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         S_INPUT: begin
            // ENTER takes priority; a coincident NEXT is dropped.
            if (BTN_ENTER) begin
`ifdef FACTOR_TIMEOUT_EN
               to_d = '0;
`endif
               if (np == que6) begin
                  state_d = S_RIGHT;
                  hold_d  = HW'(RESULT_CYC - 1);
                  din_d   = 4'd0;
                  score_d = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + 4'd1;
               end else if ((np > que6) || ((que6 % np) != 6'd0)) begin
                  state_d = S_FAIL;
                  hold_d  = HW'(RESULT_CYC - 1);
                  din_d   = 4'd0;
               end else begin
                  prod_d = np;
                  din_d  = 4'd1;
               end
            end else if (BTN_NEXT) begin
               din_d = (din_q == 4'd4) ? 4'd1 : din_q + 4'd1;
`ifdef FACTOR_TIMEOUT_EN
               to_d  = '0;
`endif
            end
`ifdef FACTOR_TIMEOUT_EN
            else if (to_q == HW'(TIMEOUT_CYC - 1)) begin
               state_d = S_FAIL;
               hold_d  = HW'(RESULT_CYC - 1);
               din_d   = 4'd0;
            end else begin
               to_d = to_q + HW'(1);
            end
`endif
         end
         S_RIGHT, S_FAIL: begin
            if (hold_q == '0)
               state_d = S_READY;
            else
               hold_d = hold_q - HW'(1);
         end
         default: state_d = S_READY;
      endcase
   end

   assign STATE = state_q;
   assign DIN   = din_q;
   assign SCORE = score_q;

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Scenario tests plus randomized run against a round-level model of the game.
module tb_factor_game_ctrl;

   localparam int SHOW = 4;
   localparam int RES  = 3;
   localparam int TMO  = 10;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN_START = 1'b0;
   logic       BTN_NEXT  = 1'b0;
   logic       BTN_ENTER = 1'b0;
   logic [3:0] STATE, QUE, DIN, SCORE;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: phase 0 ready, 1 question, 2 input, 3 right, 4 fail
   logic [3:0] code_of [0:4] = '{4'b0010, 4'b0011, 4'b0100, 4'b0111, 4'b1000};
   int         primes  [0:3] = '{2, 3, 5, 7};
   int          m_phase, m_left, m_idle, m_prod;
   int unsigned m_edges;
   logic [3:0]  m_que, m_sel, m_score;

   factor_game_ctrl #(
      .SHOW_CYC    (SHOW),
      .RESULT_CYC  (RES),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .BTN_START (BTN_START),
      .BTN_NEXT  (BTN_NEXT),
      .BTN_ENTER (BTN_ENTER),
      .STATE     (STATE),
      .QUE       (QUE),
      .DIN       (DIN),
      .SCORE     (SCORE)
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      m_phase = 0; m_left = 0; m_idle = 0; m_prod = 1; m_edges = 0;
      m_que = 4'd0; m_sel = 4'd0; m_score = 4'd0;
   endtask

   task automatic model_step(input bit s, input bit n, input bit e);
      int qv, np;
      qv = 2 + int'(m_edges % 8);
      m_edges++;
      case (m_phase)
         0: if (s) begin
               m_phase = 1; m_left = SHOW; m_que = 4'(qv); m_prod = 1;
            end
         1: begin
               m_left--;
               if (m_left == 0) begin m_phase = 2; m_sel = 4'd1; m_idle = 0; end
            end
         2: begin
               if (e) begin
                  m_idle = 0;
                  np = (m_prod * primes[int'(m_sel) - 1]) % 64;
                  if (np == int'(m_que)) begin
                     m_phase = 3; m_left = RES; m_sel = 4'd0;
                     m_score = (m_score >= 4'd9) ? 4'd9 : m_score + 4'd1;
                  end else if (np > int'(m_que) || (int'(m_que) % np) != 0) begin
                     m_phase = 4; m_left = RES; m_sel = 4'd0;
                  end else begin
                     m_prod = np; m_sel = 4'd1;
                  end
               end else if (n) begin
                  m_idle = 0;
                  m_sel = 4'(int'(m_sel) % 4 + 1);
               end else begin
                  m_idle++;
`ifdef FACTOR_TIMEOUT_EN
                  if (m_idle == TMO) begin m_phase = 4; m_left = RES; m_sel = 4'd0; end
`endif
               end
            end
         default: begin
               m_left--;
               if (m_left == 0) m_phase = 0;
            end
      endcase
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit s, input bit n, input bit e);
      BTN_START = s; BTN_NEXT = n; BTN_ENTER = e;
      @(posedge CLK);
      model_step(s, n, e);
      @(negedge CLK);
      BTN_START = 1'b0; BTN_NEXT = 1'b0; BTN_ENTER = 1'b0;
   endtask

   task automatic start_with(input int q);
      for (int i = 0; i < 8 && (2 + int'(m_edges % 8)) != q; i++) cycle(0, 0, 0);
      cycle(1, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < RES; i++) cycle(0, 0, 0);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      model_reset();
      n_chk++;
      if ({STATE, QUE, DIN, SCORE} !== {4'b0010, 4'd0, 4'd0, 4'd0})
         $display("FAIL reset_init: got %h want 2000", {STATE, QUE, DIN, SCORE});
      else n_pass++;
      RST = 1'b0;
      start_with(3);
      for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
      cycle(0, 1, 0);
      n_chk++;
      if ({STATE, DIN} !== {4'b0100, 4'd2})
         $display("FAIL pre_reset_input: got %h want 42", {STATE, DIN});
      else n_pass++;
      RST = 1'b1;
      #1;
      n_chk++;
      if ({STATE, QUE, DIN, SCORE} !== {4'b0010, 4'd0, 4'd0, 4'd0})
         $display("FAIL reset_mid_input: got %h want 2000", {STATE, QUE, DIN, SCORE});
      else n_pass++;
      @(posedge CLK); @(negedge CLK);
      model_reset();
      RST = 1'b0;
   endtask

   task automatic test_que8_three_enters();
      start_with(8);
      for (int i = 0; i < SHOW; i++) begin
         n_chk++;
         if ({STATE, QUE} !== {4'b0011, 4'd8})
            $display("FAIL q8_question c%0d: got %h want 38", i, {STATE, QUE});
         else n_pass++;
         cycle(0, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if ({STATE, DIN} !== {4'b0100, 4'd1})
            $display("FAIL q8_input c%0d: got %h want 41", i, {STATE, DIN});
         else n_pass++;
         cycle(0, 0, 1);
      end
      for (int i = 0; i < RES; i++) begin
         n_chk++;
         if ({STATE, DIN, SCORE} !== {4'b0111, 4'd0, 4'd1})
            $display("FAIL q8_right c%0d: got %h want 701", i, {STATE, DIN, SCORE});
         else n_pass++;
         cycle(0, 0, 0);
      end
      n_chk++;
      if ({STATE, SCORE} !== {4'b0010, 4'd1})
         $display("FAIL q8_ready: got %h want 21", {STATE, SCORE});
      else n_pass++;
   endtask

   task automatic test_que6_right();
      start_with(6);
      for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
      cycle(0, 1, 0);
      n_chk++;
      if (DIN !== 4'd2) $display("FAIL q6_next: got %0d want 2", DIN);
      else n_pass++;
      cycle(0, 0, 1);
      n_chk++;
      if ({STATE, DIN} !== {4'b0100, 4'd1})
         $display("FAIL q6_partial: got %h want 41", {STATE, DIN});
      else n_pass++;
      cycle(0, 0, 1);
      n_chk++;
      if ({STATE, SCORE} !== {4'b0111, 4'd2})
         $display("FAIL q6_right: got %h want 72", {STATE, SCORE});
      else n_pass++;
      drain();
   endtask

   task automatic test_que4_fail();
      start_with(4);
      for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 1);
      n_chk++;
      if ({STATE, DIN, SCORE} !== {4'b1000, 4'd0, 4'd2})
         $display("FAIL q4_fail: got %h want 802", {STATE, DIN, SCORE});
      else n_pass++;
      drain();
      n_chk++;
      if (STATE !== 4'b0010) $display("FAIL q4_ready: got %h want 2", STATE);
      else n_pass++;
   endtask

   task automatic test_back_to_back_next_enter();
      start_with(9);
      for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
      cycle(0, 1, 1);
      n_chk++;
      if ({STATE, SCORE} !== {4'b1000, 4'd2})
         $display("FAIL q9_simul: got %h want 82", {STATE, SCORE});
      else n_pass++;
      drain();
   endtask

   task automatic test_score_saturation();
      int exp_sc;
      exp_sc = 2;
      for (int r = 0; r < 9; r++) begin
         start_with(2);
         for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
         cycle(0, 0, 1);
         exp_sc = (exp_sc + 1 > 9) ? 9 : exp_sc + 1;
         n_chk++;
         if ({STATE, SCORE} !== {4'b0111, 4'(exp_sc)})
            $display("FAIL sat_round%0d: got %h want 7%0d", r, {STATE, SCORE}, exp_sc);
         else n_pass++;
         drain();
      end
   endtask

   task automatic test_timeout();
      start_with(5);
      for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
`ifdef FACTOR_TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
         n_chk++;
         if (STATE !== 4'b0100) $display("FAIL tmo_wait c%0d: got %h want 4", i, STATE);
         else n_pass++;
         cycle(0, 0, 0);
      end
      n_chk++;
      if ({STATE, SCORE} !== {4'b1000, 4'd9})
         $display("FAIL tmo_fail: got %h want 89", {STATE, SCORE});
      else n_pass++;
      drain();
      start_with(5);
      for (int i = 0; i < SHOW; i++) cycle(0, 0, 0);
      for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 0);
      cycle(0, 1, 0);
      n_chk++;
      if ({STATE, DIN} !== {4'b0100, 4'd2})
         $display("FAIL tmo_button_wins: got %h want 42", {STATE, DIN});
      else n_pass++;
      for (int i = 0; i < TMO; i++) cycle(0, 0, 0);
      n_chk++;
      if (STATE !== 4'b1000) $display("FAIL tmo_rearm: got %h want 8", STATE);
      else n_pass++;
      drain();
`else
      for (int i = 0; i < 100; i++) cycle(0, 0, 0);
      n_chk++;
      if ({STATE, DIN} !== {4'b0100, 4'd1})
         $display("FAIL no_tmo_idle: got %h want 41", {STATE, DIN});
      else n_pass++;
      cycle(0, 0, 1);
      n_chk++;
      if (STATE !== 4'b1000) $display("FAIL no_tmo_exit: got %h want 8", STATE);
      else n_pass++;
      drain();
`endif
   endtask

   task automatic test_random();
      bit s, n, e;
      for (int c = 0; c < 3000; c++) begin
         s = ($urandom_range(0, 7) == 0);
         n = ($urandom_range(0, 3) == 0);
         e = ($urandom_range(0, 4) == 0);
         cycle(s, n, e);
         n_chk++;
         if ({STATE, QUE, DIN, SCORE} !== {code_of[m_phase], m_que, m_sel, m_score})
            $display("FAIL rand c%0d: got %h want %h", c, {STATE, QUE, DIN, SCORE},
                     {code_of[m_phase], m_que, m_sel, m_score});
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      @(negedge CLK);
      test_reset();
      test_que8_three_enters();
      test_que6_right();
      test_que4_fail();
      test_back_to_back_next_enter();
      test_score_saturation();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/factor_game_ctrl.md
# factor_game_ctrl

Sequencing controller for the factorization game. It generates the `STATE`, `QUE` and `DIN` codes that the 7-segment display decoder renders. It takes debounced single-cycle button pulses, picks a question digit, and accumulates the player's prime entries into a running product. It then judges the answer as right or wrong and returns to ready. It sits between the button debouncers and the display decoder.

## Interface
Parameters:
- `SHOW_CYC`, 50_000_000: cycles the QUESTION state is held.
- `RESULT_CYC`, 50_000_000: cycles the RIGHT or FAIL state is held.
- `TIMEOUT_CYC`, 250_000_000: idle cycles allowed in INPUT before FAIL (only with the macro).

Ports:
- `CLK` in 1: the single system clock.
- `RST` in 1: reset, asynchronous and active-high.
- `BTN_START` in 1: one-cycle pulse that starts a round.
- `BTN_NEXT` in 1: one-cycle pulse that advances the prime selection.
- `BTN_ENTER` in 1: one-cycle pulse that commits the selected prime.
- `STATE` out 4: display state code.
- `QUE` out 4: question digit, range 2..9.
- `DIN` out 4: prime selection code. 1→2, 2→3, 3→5, 4→7, and 0 means none.
- `SCORE` out 4: count of rounds judged RIGHT, saturating at 9.

## Operation
- State codes:
  - READY = 4'b0010
  - QUESTION = 4'b0011
  - INPUT = 4'b0100
  - RIGHT = 4'b0111
  - FAIL = 4'b1000
  - No other code is ever driven.
- Question generator: a free-running counter cycles 2,3,…,9,2 every clock from reset value 2. `BTN_START` in READY latches its current value into `QUE`.
- READY: waits for `BTN_START`.
  - On the pulse: go to QUESTION, set product = 1, load the hold counter.
- QUESTION: holds for `SHOW_CYC` cycles.
  - Then go to INPUT with `DIN` = 1.
  - All buttons are ignored in this state.
- INPUT:
  - `BTN_NEXT`: `DIN` steps 1→2→3→4→1.
  - `BTN_ENTER`: computes np = product × prime(`DIN`), 6-bit unsigned, maximum 63.
    - If np == `QUE`: go to RIGHT.
    - Else if np > `QUE` or `QUE` mod np ≠ 0: go to FAIL.
    - Otherwise: product = np, `DIN` returns to 1, stay in INPUT.
- RIGHT / FAIL: hold for `RESULT_CYC` cycles, then go to READY.
  - Entering RIGHT increments `SCORE`, which saturates at 9.
  - `DIN` is forced to 0 in both states.
- Simultaneous `BTN_NEXT` and `BTN_ENTER`: ENTER is processed, NEXT is dropped.
- `BTN_START` outside READY is ignored.
- Reset values, applied at any time including mid-round:
  - `STATE` = READY, `QUE` = 0, `DIN` = 0, `SCORE` = 0.
  - Product = 1, question counter = 2, all hold and timeout counters = 0.

## Timing
- All outputs are registered.
- A button pulse sampled at rising edge N takes effect on the outputs after edge N, i.e. it is visible during cycle N+1. There is no further latency.
- `STATE` equals QUESTION for exactly `SHOW_CYC` cycles.
- `STATE` equals RIGHT or FAIL for exactly `RESULT_CYC` cycles.
- Multiply and judge are single-cycle combinational logic feeding the state register.
- Hold counter width is $clog2 of the largest parameter plus 1. Wrap-around never occurs, because each counter is reloaded on state entry.

## Configuration
- `FACTOR_TIMEOUT_EN` defined:
  - An inactivity counter runs in INPUT.
  - It resets on entering INPUT and on every `BTN_NEXT` or `BTN_ENTER`.
  - After `TIMEOUT_CYC` cycles without a button, go to FAIL (`SCORE` unchanged).
  - A button arriving in the same cycle as the timeout wins.
- Undefined: INPUT waits indefinitely and the counter logic is absent.

## Structure
- Package `factor_pkg` holds:
  - state code localparams;
  - `prime_of(din)` function (1..4 → 2,3,5,7, others → 1);
  - `SCORE_MAX` = 9.
- One sub-module, `factor_que_gen`: the 2..9 free-running counter with a latch-on-start output.

## Test plan
Run with `SHOW_CYC` = 4, `RESULT_CYC` = 3, `TIMEOUT_CYC` = 10.
- Reset asserted mid-INPUT → next cycle `STATE` = 4'b0010, `QUE` = 0, `DIN` = 0, `SCORE` = 0.
- START with the counter at 8; ENTER(DIN=1) three times → three INPUT cycles, then `STATE` = RIGHT for 3 cycles, then READY, `SCORE` = 1.
- QUE = 6: NEXT, ENTER (prime 3), then ENTER (prime 2) → RIGHT.
- QUE = 4: NEXT, ENTER (prime 3) → FAIL, `SCORE` unchanged.
- QUE = 9: NEXT and ENTER in the same cycle → prime 2 is committed and FAIL follows (2 does not divide 9).
- With `FACTOR_TIMEOUT_EN` defined: INPUT idle for 10 cycles → FAIL. Without it: after 100 idle cycles `STATE` is still INPUT.
